// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch/jump resolution and fetch redirect controller
module branch_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] cur_pc,
    output logic [INST_WIDTH-1:0] cur_inst,
    input  logic [ADDR_WIDTH-1:0] bra_addr,
    input  logic [ADDR_WIDTH-1:0] jal_addr,
    input  logic [ADDR_WIDTH-1:0] jalr_addr,
    input  logic [ADDR_WIDTH-1:0] data_a,
    input  logic [ADDR_WIDTH-1:0] data_b,
    input  logic                  opnd_ready,
    input  logic                  kill,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  redirect_ready,
    output logic                  flush,
    output logic                  link_valid,
    output logic [4:0]            link_rd,
    output logic [ADDR_WIDTH-1:0] link_data,
    output logic                  misalign,
    output logic [31:0]           taken_cnt
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [ADDR_WIDTH-1:0] LINK_OFS = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t state;

    logic [6:0]            cur_op;
    logic [2:0]            cur_f3;
    logic [4:0]            cur_rd;
    logic                  is_br;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  br_taken;
    logic                  resolve;
    logic                  do_jump;
    logic                  in_ctrl;
    logic [ADDR_WIDTH-1:0] target;

    assign cur_op   = cur_inst[6:0];
    assign cur_f3   = cur_inst[14:12];
    assign cur_rd   = cur_inst[11:7];
    assign in_ready = (state == IDLE) && !kill;

    // Decode the latched instruction, evaluate the branch condition and pick the target
    always_comb begin
        is_br    = (cur_op == OP_BRANCH);
        is_jal   = (cur_op == OP_JAL);
        is_jalr  = (cur_op == OP_JALR);
        in_ctrl  = (inst[6:0] == OP_BRANCH) || (inst[6:0] == OP_JAL) || (inst[6:0] == OP_JALR);
        br_taken = 1'b0;
        case (cur_f3)
            3'b000:  br_taken = (data_a == data_b);
            3'b001:  br_taken = (data_a != data_b);
            3'b100:  br_taken = ($signed(data_a) <  $signed(data_b));
            3'b101:  br_taken = ($signed(data_a) >= $signed(data_b));
            3'b110:  br_taken = (data_a <  data_b);
            3'b111:  br_taken = (data_a >= data_b);
            default: br_taken = 1'b0;
        endcase
        target = bra_addr;
        if (is_jal) begin
            target = jal_addr;
        end else if (is_jalr) begin
            target = jalr_addr;
        end
        // JAL needs no register operands, so it never waits on forwarding
        resolve = is_jal || opnd_ready;
        do_jump = is_jal || is_jalr || (is_br && br_taken);
    end

    // Control FSM with registered redirect, link and pulse outputs; kill overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cur_pc         <= '0;
            cur_inst       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            link_valid     <= 1'b0;
            link_rd        <= '0;
            link_data      <= '0;
            misalign       <= 1'b0;
            taken_cnt      <= '0;
        end else begin
            flush      <= 1'b0;
            link_valid <= 1'b0;
            misalign   <= 1'b0;
            if (kill) begin
                state          <= IDLE;
                redirect_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // Non-control opcodes are consumed and dropped
                        if (in_valid && in_ctrl) begin
                            cur_pc   <= pc;
                            cur_inst <= inst;
                            state    <= EVAL;
                        end
                    end
                    EVAL: begin
                        if (resolve) begin
                            if (!do_jump) begin
                                state <= IDLE;
                            end else begin
                                redirect_pc <= target;
                                if (target[1]) begin
                                    misalign <= 1'b1;
                                    state    <= IDLE;
                                end else begin
                                    redirect_valid <= 1'b1;
                                    flush          <= 1'b1;
                                    state          <= REDIRECT;
                                    if (!is_br && (cur_rd != 5'd0)) begin
                                        link_valid <= 1'b1;
                                        link_rd    <= cur_rd;
                                        link_data  <= cur_pc + LINK_OFS;
                                    end
                                end
                            end
                        end
                    end
                    REDIRECT: begin
                        if (redirect_ready) begin
                            redirect_valid <= 1'b0;
                            taken_cnt      <= taken_cnt + 32'd1;
                            state          <= IDLE;
                        end
                    end
                    default: begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        opnd_ready = 1'b0;
    logic        kill = 1'b0;
    logic        redirect_valid;
    logic        redirect_ready = 1'b0;
    logic        flush;
    logic        link_valid;
    logic        misalign;
    logic [63:0] pc = '0;
    logic [63:0] cur_pc;
    logic [63:0] bra_addr = '0;
    logic [63:0] jal_addr = '0;
    logic [63:0] jalr_addr = '0;
    logic [63:0] data_a = '0;
    logic [63:0] data_b = '0;
    logic [63:0] redirect_pc;
    logic [63:0] link_data;
    logic [31:0] inst = '0;
    logic [31:0] cur_inst;
    logic [31:0] taken_cnt;
    logic [4:0]  link_rd;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = '0;
    logic [63:0] mdl_pc = '0;

    branch_ctrl #(.ADDR_WIDTH(64), .INST_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .inst(inst), .cur_pc(cur_pc), .cur_inst(cur_inst),
        .bra_addr(bra_addr), .jal_addr(jal_addr), .jalr_addr(jalr_addr),
        .data_a(data_a), .data_b(data_b), .opnd_ready(opnd_ready), .kill(kill),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush(flush), .link_valid(link_valid),
        .link_rd(link_rd), .link_data(link_data), .misalign(misalign),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic bit model_taken(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] p, input logic [31:0] i);
        pc = p;
        inst = i;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if ({redirect_valid, flush, link_valid, misalign} !== 4'b0) begin errors++; $display("FAIL reset_pulses got=%b exp=0000", {redirect_valid, flush, link_valid, misalign}); end
        checks++; if (taken_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0h exp=0", taken_cnt); end
        checks++; if ({cur_pc, redirect_pc, link_data} !== 192'd0) begin errors++; $display("FAIL reset_regs cur_pc=%0h redirect_pc=%0h link_data=%0h exp=0", cur_pc, redirect_pc, link_data); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        exp_cnt = 32'd0;
    endtask

    task automatic test_beq();
        data_a = 64'd5; data_b = 64'd5; opnd_ready = 1'b1; redirect_ready = 1'b1;
        bra_addr = 64'h1010; jal_addr = 64'h7770; jalr_addr = 64'h8880;
        pc = 64'h1000; inst = enc_b(3'b000, 13'd16); in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL beq_accept got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (cur_pc !== 64'h1000 || cur_inst !== enc_b(3'b000, 13'd16)) begin errors++; $display("FAIL beq_latch cur_pc=%0h cur_inst=%0h exp pc=1000", cur_pc, cur_inst); end
        checks++; if ({in_ready, redirect_valid} !== 2'b00) begin errors++; $display("FAIL beq_eval got=%b exp=00", {in_ready, redirect_valid}); end
        step();
        checks++; if ({redirect_valid, flush, link_valid, misalign} !== 4'b1100) begin errors++; $display("FAIL beq_t2 got=%b exp=1100", {redirect_valid, flush, link_valid, misalign}); end
        checks++; if (redirect_pc !== 64'h1010) begin errors++; $display("FAIL beq_target got=%0h exp=1010", redirect_pc); end
        step();
        exp_cnt++;
        checks++; if ({redirect_valid, flush, in_ready} !== 3'b001) begin errors++; $display("FAIL beq_t3 got=%b exp=001", {redirect_valid, flush, in_ready}); end
        checks++; if (taken_cnt !== exp_cnt) begin errors++; $display("FAIL beq_cnt got=%0d exp=%0d", taken_cnt, exp_cnt); end
    endtask

    task automatic test_blt_bltu();
        data_a = '1; data_b = 64'd1; opnd_ready = 1'b1; redirect_ready = 1'b1;
        bra_addr = 64'h1008;
        issue(64'h1000, enc_b(3'b100, 13'd8));
        step();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h1008) begin errors++; $display("FAIL blt_taken valid=%b pc=%0h exp 1/1008", redirect_valid, redirect_pc); end
        step();
        exp_cnt++;
        checks++; if (taken_cnt !== exp_cnt) begin errors++; $display("FAIL blt_cnt got=%0d exp=%0d", taken_cnt, exp_cnt); end
        issue(64'h1000, enc_b(3'b110, 13'd8));
        step();
        checks++; if ({redirect_valid, flush, misalign, in_ready} !== 4'b0001) begin errors++; $display("FAIL bltu_not_taken got=%b exp=0001", {redirect_valid, flush, misalign, in_ready}); end
        checks++; if (taken_cnt !== exp_cnt) begin errors++; $display("FAIL bltu_cnt got=%0d exp=%0d", taken_cnt, exp_cnt); end
    endtask

    task automatic test_jalr();
        opnd_ready = 1'b0; redirect_ready = 1'b1;
        data_a = 64'h2001; jalr_addr = 64'h2000; bra_addr = 64'h3000; jal_addr = 64'h4000;
        issue(64'h1000, enc_jalr(5'd1, 12'd0));
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if ({in_ready, redirect_valid, link_valid, flush} !== 4'b0) begin errors++; $display("FAIL jalr_hold%0d got=%b exp=0000", k, {in_ready, redirect_valid, link_valid, flush}); end
        end
        opnd_ready = 1'b1;
        step();
        checks++; if ({link_valid, redirect_valid, flush} !== 3'b111) begin errors++; $display("FAIL jalr_resolve got=%b exp=111", {link_valid, redirect_valid, flush}); end
        checks++; if (link_rd !== 5'd1 || link_data !== 64'h1004) begin errors++; $display("FAIL jalr_link rd=%0d data=%0h exp 1/1004", link_rd, link_data); end
        checks++; if (redirect_pc !== 64'h2000) begin errors++; $display("FAIL jalr_target got=%0h exp=2000", redirect_pc); end
        step();
        exp_cnt++;
        checks++; if ({link_valid, redirect_valid} !== 2'b00 || taken_cnt !== exp_cnt) begin errors++; $display("FAIL jalr_done lv/rv=%b cnt=%0d exp 00/%0d", {link_valid, redirect_valid}, taken_cnt, exp_cnt); end
    endtask

    task automatic test_jal_stall();
        redirect_ready = 1'b0; opnd_ready = 1'b0;
        jal_addr = 64'h1100; bra_addr = 64'h5000; jalr_addr = 64'h6000;
        issue(64'h1000, enc_jal(5'd0, 21'h100));
        step();
        for (int k = 0; k < 5; k++) begin
            checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h1100 || link_valid !== 1'b0 || flush !== (k == 0)) begin
                errors++; $display("FAIL jal_stall%0d rv=%b pc=%0h lv=%b flush=%b exp 1/1100/0/%b", k, redirect_valid, redirect_pc, link_valid, flush, (k == 0));
            end
            if (k == 4) redirect_ready = 1'b1;
            step();
        end
        exp_cnt++;
        checks++; if (redirect_valid !== 1'b0 || taken_cnt !== exp_cnt || in_ready !== 1'b1) begin errors++; $display("FAIL jal_done rv=%b cnt=%0d rdy=%b exp 0/%0d/1", redirect_valid, taken_cnt, in_ready, exp_cnt); end
    endtask

    task automatic test_kill();
        redirect_ready = 1'b0; opnd_ready = 1'b1;
        data_a = 64'd7; data_b = 64'd7; bra_addr = 64'h1040;
        issue(64'h1000, enc_b(3'b000, 13'h40));
        step();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL kill_pre got=%b exp=1", redirect_valid); end
        kill = 1'b1; redirect_ready = 1'b1;
        step();
        checks++; if ({redirect_valid, flush} !== 2'b00 || taken_cnt !== exp_cnt) begin errors++; $display("FAIL kill_redirect rv/flush=%b cnt=%0d exp 00/%0d", {redirect_valid, flush}, taken_cnt, exp_cnt); end
        kill = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kill_idle got=%b exp=1", in_ready); end
        jal_addr = 64'h1200;
        issue(64'h1000, enc_jal(5'd3, 21'h200));
        kill = 1'b1;
        step();
        checks++; if ({link_valid, flush, redirect_valid, misalign, in_ready} !== 5'b0) begin errors++; $display("FAIL kill_eval got=%b exp=00000", {link_valid, flush, redirect_valid, misalign, in_ready}); end
        kill = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kill_eval_idle got=%b exp=1", in_ready); end
        redirect_ready = 1'b1;
    endtask

    task automatic test_misalign();
        data_a = 64'd0; data_b = 64'd0; opnd_ready = 1'b1; redirect_ready = 1'b1;
        bra_addr = 64'h1006;
        issue(64'h1000, enc_b(3'b000, 13'd6));
        step();
        checks++; if ({misalign, redirect_valid, flush, in_ready} !== 4'b1001) begin errors++; $display("FAIL mis_br got=%b exp=1001", {misalign, redirect_valid, flush, in_ready}); end
        step();
        checks++; if (misalign !== 1'b0 || taken_cnt !== exp_cnt) begin errors++; $display("FAIL mis_pulse mis=%b cnt=%0d exp 0/%0d", misalign, taken_cnt, exp_cnt); end
        jal_addr = 64'h1002;
        issue(64'h1000, enc_jal(5'd5, 21'd2));
        step();
        checks++; if ({misalign, link_valid, redirect_valid} !== 3'b100) begin errors++; $display("FAIL mis_jal got=%b exp=100", {misalign, link_valid, redirect_valid}); end
        mdl_pc = 64'h1000;
    endtask

    task automatic test_non_ctrl();
        issue(64'h3000, 32'h0020_80b3);
        checks++; if (in_ready !== 1'b1 || cur_pc !== mdl_pc || redirect_valid !== 1'b0) begin errors++; $display("FAIL non_ctrl rdy=%b cur_pc=%0h rv=%b exp 1/%0h/0", in_ready, cur_pc, redirect_valid, mdl_pc); end
    endtask

    task automatic test_random();
        logic [63:0] vals [6];
        logic [63:0] p, a, b, tgt;
        logic [31:0] i;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        int          kind, opd, rdy;
        bit          mis, jump, exp_link, exp_rv, exp_mis;
        vals = '{64'd0, 64'd1, {64{1'b1}}, 64'd5, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            f3   = 3'($urandom_range(0, 7));
            rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            p    = {$urandom, $urandom} & ~64'h3;
            if (n == 5) p = 64'hFFFF_FFFF_FFFF_FFFC;
            a    = vals[$urandom_range(0, 5)];
            b    = vals[$urandom_range(0, 5)];
            mis  = ($urandom_range(0, 3) == 0);
            tgt  = ((p + {32'd0, $urandom}) & ~64'h3) | (mis ? 64'h2 : 64'h0);
            op   = (kind == 0) ? 7'b1100011 : (kind == 1) ? 7'b1101111 : (kind == 2) ? 7'b1100111 : 7'b0010011;
            i    = $urandom;
            i[6:0] = op; i[14:12] = f3; i[11:7] = rd;
            opd  = $urandom_range(0, 3);
            rdy  = $urandom_range(0, 3);
            jump     = (kind == 1) || (kind == 2) || (kind == 0 && model_taken(f3, a, b));
            exp_link = (kind == 1 || kind == 2) && (rd != 5'd0) && !mis;
            exp_rv   = jump && !mis;
            exp_mis  = jump && mis;
            bra_addr  = (kind == 0) ? tgt : tgt ^ 64'h40;
            jal_addr  = (kind == 1) ? tgt : tgt ^ 64'h80;
            jalr_addr = (kind == 2) ? tgt : tgt ^ 64'hC0;
            data_a = a; data_b = b; redirect_ready = 1'b0;
            opnd_ready = (kind == 1) ? 1'($urandom_range(0, 1)) : (opd == 0);
            issue(p, i);
            if (kind == 3) begin
                checks++; if (in_ready !== 1'b1 || cur_pc !== mdl_pc || redirect_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_drop rdy=%b cur_pc=%0h exp 1/%0h", n, in_ready, cur_pc, mdl_pc); end
                continue;
            end
            mdl_pc = p;
            checks++; if (cur_pc !== p) begin errors++; $display("FAIL rnd%0d_latch got=%0h exp=%0h", n, cur_pc, p); end
            if (kind != 1) begin
                for (int k = 0; k < opd; k++) begin
                    step();
                    checks++; if ({in_ready, redirect_valid, link_valid, flush, misalign} !== 5'b0) begin errors++; $display("FAIL rnd%0d_hold got=%b exp=00000", n, {in_ready, redirect_valid, link_valid, flush, misalign}); end
                end
                opnd_ready = 1'b1;
            end
            step();
            checks++; if ({redirect_valid, flush, misalign, link_valid} !== {exp_rv, exp_rv, exp_mis, exp_link}) begin
                errors++; $display("FAIL rnd%0d_resolve kind=%0d f3=%0d got=%b exp=%b", n, kind, f3, {redirect_valid, flush, misalign, link_valid}, {exp_rv, exp_rv, exp_mis, exp_link});
            end
            if (exp_link) begin
                checks++; if (link_rd !== rd || link_data !== p + 64'd4) begin errors++; $display("FAIL rnd%0d_link rd=%0d data=%0h exp %0d/%0h", n, link_rd, link_data, rd, p + 64'd4); end
            end
            if (exp_rv) begin
                checks++; if (redirect_pc !== tgt) begin errors++; $display("FAIL rnd%0d_target got=%0h exp=%0h", n, redirect_pc, tgt); end
                for (int k = 0; k < rdy; k++) begin
                    step();
                    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== tgt || flush !== 1'b0) begin errors++; $display("FAIL rnd%0d_stall rv=%b pc=%0h flush=%b exp 1/%0h/0", n, redirect_valid, redirect_pc, flush, tgt); end
                end
                redirect_ready = 1'b1;
                step();
                exp_cnt++;
                checks++; if (redirect_valid !== 1'b0 || taken_cnt !== exp_cnt) begin errors++; $display("FAIL rnd%0d_done rv=%b cnt=%0d exp 0/%0d", n, redirect_valid, taken_cnt, exp_cnt); end
                redirect_ready = 1'b0;
            end else begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_idle got=%b exp=1", n, in_ready); end
            end
        end
    endtask

    task automatic test_reset_async();
        opnd_ready = 1'b0; redirect_ready = 1'b0;
        jalr_addr = 64'h2000;
        issue(64'h1000, enc_jalr(5'd1, 12'd0));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({redirect_valid, flush, link_valid, misalign} !== 4'b0) begin errors++; $display("FAIL async_eval_pulses got=%b exp=0000", {redirect_valid, flush, link_valid, misalign}); end
        checks++; if (cur_pc !== 64'd0 || cur_inst !== 32'd0 || taken_cnt !== 32'd0) begin errors++; $display("FAIL async_eval_regs cur_pc=%0h cur_inst=%0h cnt=%0d exp 0", cur_pc, cur_inst, taken_cnt); end
        exp_cnt = 32'd0;
        step();
        rst_n = 1'b1;
        opnd_ready = 1'b1; data_a = 64'd9; data_b = 64'd9; bra_addr = 64'h1020;
        issue(64'h1000, enc_b(3'b000, 13'h20));
        step();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL async_pre got=%b exp=1", redirect_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({redirect_valid, flush} !== 2'b00 || redirect_pc !== 64'd0) begin errors++; $display("FAIL async_redirect rv/flush=%b pc=%0h exp 00/0", {redirect_valid, flush}, redirect_pc); end
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_release got=%b exp=1", in_ready); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_beq();
        test_blt_bltu();
        test_jalr();
        test_jal_stall();
        test_kill();
        test_misalign();
        test_non_ctrl();
        test_random();
        test_reset_async();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, the PC/operand/target width.
REQ-002 SHALL have parameter INST_WIDTH, default 32, the instruction width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1, the instruction handshake from decode.
REQ-006 SHALL have ports pc input ADDR_WIDTH and inst input INST_WIDTH, the offered instruction and its address.
REQ-007 SHALL have ports cur_pc output ADDR_WIDTH and cur_inst output INST_WIDTH, the latched instruction driven to the branch target calculator.
REQ-008 SHALL have inputs bra_addr, jal_addr, jalr_addr (each ADDR_WIDTH), the calculator's targets for cur_pc/cur_inst.
REQ-009 SHALL have inputs data_a, data_b (ADDR_WIDTH) and opnd_ready (1), the rs1/rs2 values and their validity from forwarding.
REQ-010 SHALL have input kill (1), a higher-priority pipeline flush.
REQ-011 SHALL have outputs redirect_valid (1), redirect_pc (ADDR_WIDTH), input redirect_ready (1), the fetch redirect handshake.
REQ-012 SHALL have output flush (1), a one-cycle younger-instruction squash pulse.
REQ-013 SHALL have outputs link_valid (1), link_rd (5), link_data (ADDR_WIDTH), the return-address writeback.
REQ-014 SHALL have outputs misalign (1), a one-cycle pulse, and taken_cnt (32), a count of completed redirects.

Function
REQ-015 SHALL implement the FSM states IDLE, EVAL and REDIRECT.
REQ-016 In IDLE, in_ready SHALL be 1 unless kill=1; every other state SHALL drive in_ready=0.
REQ-017 When in_valid & in_ready and opcode is 1100011, 1101111 or 1100111, the block SHALL latch pc/inst into cur_pc/cur_inst and enter EVAL; any other opcode SHALL be consumed with no effect.
REQ-018 In EVAL for JAL, the block SHALL resolve in that cycle regardless of opnd_ready.
REQ-019 In EVAL for a branch or JALR with opnd_ready=0, the block SHALL remain in EVAL with no side effects.
REQ-020 Branch funct3 SHALL decode as BEQ 000, BNE 001, BLT 100 (signed), BGE 101 (signed), BLTU 110, BGEU 111, with funct3 010/011 resolving not-taken.
REQ-021 A not-taken branch SHALL return to IDLE with no redirect and no flush.
REQ-022 On resolution the target SHALL be bra_addr (taken branch), jal_addr (JAL) or jalr_addr (JALR), registered into redirect_pc.
REQ-023 If target[1]=1, the block SHALL pulse misalign for 1 cycle, return to IDLE, and issue no redirect, flush or link.
REQ-024 Otherwise the block SHALL enter REDIRECT, and flush SHALL pulse high in the first REDIRECT cycle only.
REQ-025 For JAL/JALR with rd≠0, link_valid SHALL pulse for one cycle at resolution, with link_rd=inst[11:7] and link_data=cur_pc+4 (mod 2^ADDR_WIDTH); a misaligned target suppresses this pulse per REQ-023.
REQ-026 In REDIRECT, redirect_valid SHALL be 1 with redirect_pc held stable until redirect_ready=1.
REQ-027 The redirect_valid & redirect_ready cycle SHALL return the block to IDLE and increment taken_cnt, which wraps at 2^32.
REQ-028 Minimum latency SHALL be accept at cycle T, resolution at T+1, and redirect_valid plus flush at T+2.
REQ-029 kill=1 SHALL force IDLE at the next edge from any state, dropping redirect_valid and suppressing link_valid, flush and misalign in that cycle.
REQ-030 kill SHALL take priority over resolution and over the redirect handshake, and taken_cnt SHALL NOT increment when kill aborts.

Reset
REQ-031 When rst_n=0, the block SHALL immediately (asynchronously) force state IDLE, and cur_pc, cur_inst, redirect_pc, link_rd, link_data and taken_cnt to 0.
REQ-032 When rst_n=0, the block SHALL force redirect_valid, flush, link_valid and misalign to 0.
REQ-033 The first cycle after reset release SHALL have in_ready=1 when kill=0.
REQ-034 A reset asserted mid-REDIRECT SHALL drop redirect_valid within the same cycle, without waiting for a clock edge.

Verification
REQ-035 The bench SHALL cover: BEQ at pc=0x1000, imm=+16, data_a=data_b=5, redirect_ready=1 -> redirect_pc=0x1010 at T+2, flush 1 cycle, taken_cnt=1.
REQ-036 The bench SHALL cover: BLT with data_a=-1, data_b=1 -> taken; BLTU with the same operands -> not taken, back to IDLE at T+2, no flush.
REQ-037 The bench SHALL cover: JALR at pc=0x1000, rd=1, imm=0, data_a=0x2001, with opnd_ready low 3 cycles -> EVAL held 3 cycles, then link_valid with link_data=0x1004, link_rd=1, and redirect_pc=0x2000.
REQ-038 The bench SHALL cover: JAL with rd=0 and redirect_ready low 4 cycles -> redirect_valid and redirect_pc stable for 5 cycles, link_valid never asserted.
REQ-039 The bench SHALL cover: kill asserted in REDIRECT -> redirect_valid=0 next cycle, state IDLE, taken_cnt unchanged.
REQ-040 The bench SHALL cover: a branch whose target has bit 1 set -> misalign pulse, no redirect; and rst_n low mid-EVAL -> all outputs 0 at once.
